// File: rtl/fpu_move_pipe.sv
// FP<->integer move and sign-injection unit with a 2-entry valid/ready result queue.
// Operand width is Std+1 bits (31 -> IEEE754 single, 15 -> bfloat16).
module fpu_move_pipe #(
    parameter int unsigned Std = 31
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     opcode,
    input  logic [Std:0]   rs1,
    input  logic [Std:0]   rs2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Std:0]   result,
    output logic           illegal
);

    localparam int unsigned W     = Std + 1;
    localparam int unsigned DEPTH = 2;

    localparam logic [2:0] OP_FMV_W_X = 3'b001;
    localparam logic [2:0] OP_FMV_X_W = 3'b010;
    localparam logic [2:0] OP_FSGNJ   = 3'b011;
    localparam logic [2:0] OP_FSGNJN  = 3'b100;
    localparam logic [2:0] OP_FSGNJX  = 3'b101;

    logic [W-1:0] q_res [DEPTH];
    logic         q_ill [DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    logic [W-1:0] calc_res;
    logic         calc_ill;
    logic         accept;
    logic         pop;

    // Operation decode; bit-exact, no canonicalisation or flags.
    always_comb begin
        calc_res = '0;
        calc_ill = 1'b0;
        unique case (opcode)
            OP_FMV_W_X: calc_res = rs1;
            OP_FMV_X_W: calc_res = rs1;
            OP_FSGNJ:   calc_res = {rs2[Std], rs1[Std-1:0]};
            OP_FSGNJN:  calc_res = {~rs2[Std], rs1[Std-1:0]};
            OP_FSGNJX:  calc_res = {rs1[Std] ^ rs2[Std], rs1[Std-1:0]};
            default: begin
                calc_res = '0;
                calc_ill = 1'b1;
            end
        endcase
    end

    // Handshake status comes only from registered queue state.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign result    = out_valid ? q_res[rd_ptr] : '0;
    assign illegal   = out_valid ? q_ill[rd_ptr] : 1'b0;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                q_res[i] <= '0;
                q_ill[i] <= 1'b0;
            end
        end else begin
            if (accept) begin
                q_res[wr_ptr] <= calc_res;
                q_ill[wr_ptr] <= calc_ill;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (accept && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !accept) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_move_pipe.sv
// Directed bench for fpu_move_pipe: single-precision and bfloat16 instances.
module tb_fpu_move_pipe;

    logic        clk;
    logic        rst_l;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_illegal;
    logic [2:0]  a_opcode;
    logic [31:0] a_rs1, a_rs2, a_result;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_illegal;
    logic [2:0]  b_opcode;
    logic [15:0] b_rs1, b_rs2, b_result;

    int n_vec = 0;
    int n_err = 0;

    fpu_move_pipe #(.Std(31)) dut_a (
        .clk       (clk),
        .rst_l     (rst_l),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .opcode    (a_opcode),
        .rs1       (a_rs1),
        .rs2       (a_rs2),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .result    (a_result),
        .illegal   (a_illegal)
    );

    fpu_move_pipe #(.Std(15)) dut_b (
        .clk       (clk),
        .rst_l     (rst_l),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .opcode    (b_opcode),
        .rs1       (b_rs1),
        .rs2       (b_rs2),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .result    (b_result),
        .illegal   (b_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_l = 1'b0;
        a_in_valid = 1'b0; a_opcode = 3'b000; a_rs1 = '0; a_rs2 = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_opcode = 3'b000; b_rs1 = '0; b_rs2 = '0; b_out_ready = 1'b1;
        @(negedge clk);
        step();
        step();

        chk("rst_in_ready",  32'(a_in_ready),  32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_result",    a_result,         32'h0);
        chk("rst_illegal",   32'(a_illegal),   32'd0);
        rst_l = 1'b1;

        // FSGNJ: sign from rs2
        a_in_valid = 1'b1; a_opcode = 3'b011; a_rs1 = 32'h3F800000; a_rs2 = 32'h80000000;
        step();
        chk("fsgnj_valid",   32'(a_out_valid), 32'd1);
        chk("fsgnj_result",  a_result,         32'hBF800000);
        chk("fsgnj_illegal", 32'(a_illegal),   32'd0);

        // FSGNJN then FSGNJX back to back
        a_opcode = 3'b100; a_rs1 = 32'hC0400000; a_rs2 = 32'hC0000000;
        step();
        chk("fsgnjn_valid",  32'(a_out_valid), 32'd1);
        chk("fsgnjn_result", a_result,         32'h40400000);
        a_opcode = 3'b101;
        step();
        chk("fsgnjx_valid",  32'(a_out_valid), 32'd1);
        chk("fsgnjx_result", a_result,         32'h40400000);
        a_in_valid = 1'b0;
        step();
        chk("drain_valid",   32'(a_out_valid), 32'd0);
        chk("drain_result",  a_result,         32'h0);

        // Backpressure: fill the queue
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_opcode = 3'b001; a_rs1 = 32'h11111111; a_rs2 = 32'hFFFFFFFF;
        step();
        chk("bp1_in_ready", 32'(a_in_ready), 32'd1);
        chk("bp1_head",     a_result,        32'h11111111);
        a_opcode = 3'b010; a_rs1 = 32'h22222222;
        step();
        chk("bp2_in_ready", 32'(a_in_ready), 32'd0);
        chk("bp2_head",     a_result,        32'h11111111);
        a_opcode = 3'b001; a_rs1 = 32'h33333333;
        step();
        chk("bp3_in_ready", 32'(a_in_ready), 32'd0);
        chk("bp3_head",     a_result,        32'h11111111);
        chk("bp3_valid",    32'(a_out_valid), 32'd1);

        // Full with simultaneous pop: third op must not enter this edge
        a_out_ready = 1'b1;
        step();
        chk("fullpop_head",     a_result,         32'h22222222);
        chk("fullpop_in_ready", 32'(a_in_ready),  32'd1);
        step();
        chk("rel_head3",        a_result,         32'h33333333);
        chk("rel_in_ready",     32'(a_in_ready),  32'd1);
        a_in_valid = 1'b0;
        step();
        chk("rel_empty",        32'(a_out_valid), 32'd0);

        // Undefined opcodes on the wide instance
        a_in_valid = 1'b1; a_opcode = 3'b000; a_rs1 = 32'hDEADBEEF; a_rs2 = 32'h12345678;
        step();
        chk("op000_result",  a_result,        32'h0);
        chk("op000_illegal", 32'(a_illegal), 32'd1);
        a_opcode = 3'b110;
        step();
        chk("op110_result",  a_result,        32'h0);
        chk("op110_illegal", 32'(a_illegal), 32'd1);
        a_in_valid = 1'b0;
        step();
        chk("op_empty_illegal", 32'(a_illegal), 32'd0);

        // bfloat16 instance
        b_in_valid = 1'b1; b_opcode = 3'b101; b_rs1 = 16'hBF80; b_rs2 = 16'h8000;
        step();
        chk("bf_fsgnjx",         32'(b_result),  32'h3F80);
        chk("bf_fsgnjx_illegal", 32'(b_illegal), 32'd0);
        b_opcode = 3'b111;
        step();
        chk("bf_op111_result",  32'(b_result),  32'h0);
        chk("bf_op111_illegal", 32'(b_illegal), 32'd1);
        b_opcode = 3'b100; b_rs1 = 16'h4049; b_rs2 = 16'h0000;
        step();
        chk("bf_fsgnjn", 32'(b_result), 32'hC049);
        b_in_valid = 1'b0;
        step();
        chk("bf_empty", 32'(b_out_valid), 32'd0);

        // Reset with a full queue discards contents
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_opcode = 3'b001; a_rs1 = 32'h55555555;
        step();
        a_rs1 = 32'h66666666;
        step();
        chk("prerst_in_ready", 32'(a_in_ready), 32'd0);
        rst_l = 1'b0;
        a_rs1 = 32'h77777777;
        step();
        chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
        chk("midrst_result",    a_result,         32'h0);
        chk("midrst_in_ready",  32'(a_in_ready),  32'd1);
        rst_l = 1'b1;
        a_out_ready = 1'b1;
        a_rs1 = 32'hA5A5A5A5;
        step();
        chk("postrst_result", a_result,         32'hA5A5A5A5);
        chk("postrst_valid",  32'(a_out_valid), 32'd1);
        a_in_valid = 1'b0;
        step();
        chk("postrst_empty",  32'(a_out_valid), 32'd0);
        chk("postrst_zero",   a_result,         32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_move_pipe.md
# fpu_move_pipe

Parametrised, handshaked successor to the FPU move path: performs FP↔integer register moves and the three sign-injection operations (FSGNJ/FSGNJN/FSGNJX) on a configurable operand width, and buffers results in a 2-entry output queue with valid/ready flow control. It sits between the FPU decode/issue stage and the FPU result-writeback arbiter. Width 16 serves the bfloat16 datapath and width 32 serves IEEE754 single precision.

## Interface
- Std, 31: MSB index of operands and result. 31 gives IEEE754 single; 15 gives bfloat16. Any value ≥ 1 is legal.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_l  in  1  reset; one clock; reset is synchronous and active-low.
- in_valid  in  1  issue side presents an operation.
- in_ready  out  1  block can accept an operation this cycle.
- opcode  in  3  operation select, decoded below.
- rs1  in  Std+1  source operand 1: magnitude/payload source.
- rs2  in  Std+1  source operand 2: sign source.
- out_valid  out  1  queue head holds a result.
- out_ready  in  1  writeback consumes the head this cycle.
- result  out  Std+1  head result; all zeros when out_valid=0.
- illegal  out  1  head result came from an undefined opcode; 0 when out_valid=0.

## Operation
- Opcode decode, with M = rs1[Std-1:0]:
  - 001 FMV.W.X (int→fp): rs1.
  - 010 FMV.X.W (fp→int): rs1.
  - 011 FSGNJ: {rs2[Std], M}.
  - 100 FSGNJN: {~rs2[Std], M}.
  - 101 FSGNJX: {rs1[Std]^rs2[Std], M}.
  - 000, 110, 111: result all zeros, illegal=1.
- Results are bit-exact. There is no NaN canonicalisation, no exception flags and no rounding.
- Accept: in_valid & in_ready at a rising edge. The computed {illegal, result} is written to the tail entry.
- Pop: out_valid & out_ready at a rising edge retires the head.
- Queue: 2 entries, 1-bit write and read pointers that wrap 1→0, and a 2-bit count (0..2).
- in_ready = (count != 2). It is registered state only and has no combinational path from out_ready.
- Simultaneous accept and pop:
  - At count=1: count stays 1, both pointers advance.
  - At count=0: only the accept happens, because out_valid=0.
  - At count=2: only the pop happens, because in_ready=0.
- Reset while rst_l=0 at an edge:
  - count=0, both pointers=0, all entries cleared to zero.
  - Any in-flight or queued results are discarded.
  - in_valid is ignored during reset.
- Reset values of outputs: in_ready=1, out_valid=0, result=0, illegal=0.

## Timing
- Latency is 1 cycle. An operation accepted at edge N appears on result/out_valid after edge N when the queue was empty.
- Throughput is 1 op/cycle sustained while out_ready=1.
- With out_ready=0, 2 ops are accepted, then in_ready=0 from the cycle after the second accept.
- Once out_ready=1, in_ready returns to 1 the cycle after the first pop.
- FIFO order is strict. result and illegal are stable while out_valid=1 and out_ready=0.
- Combinational outputs result, illegal and out_valid depend only on registered state.

## Test plan
- Reset, then Std=31, opcode=011, rs1=32'h3F800000, rs2=32'h80000000, out_ready=1 → the next cycle gives out_valid=1, result=32'hBF800000, illegal=0.
- Back-to-back FSGNJN then FSGNJX with rs1=32'hC0400000, rs2=32'hC0000000, out_ready=1 → consecutive cycles give result=32'h40400000 then 32'h40400000. Both are 1-cycle latency with no bubbles.
- Backpressure:
  - Stimulus: out_ready=0; issue 3 ops with FMV rs1 = 32'h11111111, 32'h22222222, 32'h33333333.
  - Expected while held: in_ready=0 after the second accept and the third op is held; head stays 32'h11111111.
  - Release: raise out_ready → pops 1111…, 2222…, 3333… in order.
- Full with simultaneous pop: at count=2 with out_ready=1 and in_valid=1 → the head pops, the new op is not accepted that cycle, and in_ready=1 the next cycle.
- Std=15, opcode=101, rs1=16'hBF80, rs2=16'h8000 → result=16'h3F80. Opcode=111 → result=16'h0000, illegal=1.
- Queue holds 2 entries and rst_l=0 for one edge → out_valid=0, result=0, in_ready=1. The first op after reset emerges with no stale data.
